// File: rtl/lut_sweep_capture_pkg.sv
// Shared definitions for the LUT sweep-and-capture stage.
// This file holds the state encodings, default sizing and the settle-counter width helper.
package lut_sweep_capture_pkg;

    localparam int LSC_N_IN   = 3;
    localparam int LSC_SETTLE = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // The counter must hold SETTLE-1 and must be at least one bit wide.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/lut_sweep_capture_settle_timer.sv
// Loadable down-counter that pulses o_expire on the SETTLE-th enabled cycle after a load.
// It reloads itself on expiry, so consecutive vectors need no extra load.
module lut_sweep_capture_settle_timer
    import lut_sweep_capture_pkg::*;
#(
    parameter int SETTLE = LSC_SETTLE
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int              CW     = cnt_width(SETTLE);
    localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == {CW{1'b0}});

    // Down-count while enabled; reload on an explicit load or on expiry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_load || o_expire) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= r_cnt - CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/lut_sweep_capture.sv
// Sweeps every input vector onto a LUT, captures its truth table and compares it
// against a golden table latched at start.
module lut_sweep_capture
    import lut_sweep_capture_pkg::*;
#(
    parameter  int N_IN   = LSC_N_IN,
    parameter  int SETTLE = LSC_SETTLE,
    localparam int N_VEC  = 1 << N_IN
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [N_VEC-1:0] i_expected,
    output logic [N_IN-1:0]  o_lut_in,
    input  logic             i_lut_f,
    output logic             o_busy,
    output logic             o_done,
    output logic [N_VEC-1:0] o_table,
    output logic             o_match,
    output logic [N_IN:0]    o_mismatch_count
);

    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(N_VEC - 1);

    logic [1:0]       r_state;
    logic [N_IN-1:0]  r_idx;
    logic [N_VEC-1:0] r_exp;
    logic [N_VEC-1:0] r_table;
    logic [N_IN:0]    r_mm;
    logic             r_busy;
    logic             r_done;
    logic             r_match;

    logic             w_accept;
    logic             w_expire;
    logic             w_last;
    logic             w_miss;
    logic [N_IN:0]    w_mm_next;

    assign w_accept  = (r_state == ST_IDLE) && i_start;
    assign w_last    = (r_idx == IDX_LAST);
    assign w_miss    = i_lut_f ^ r_exp[r_idx];
    assign w_mm_next = r_mm + {{N_IN{1'b0}}, w_miss};

    lut_sweep_capture_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_accept),
        .i_en     (r_state == ST_DRIVE),
        .o_expire (w_expire)
    );

    // Sweep FSM with index stepping, table capture and mismatch accumulation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= {N_IN{1'b0}};
            r_exp   <= {N_VEC{1'b0}};
            r_table <= {N_VEC{1'b0}};
            r_mm    <= {(N_IN+1){1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= ST_DRIVE;
                        r_exp   <= i_expected;
                        r_table <= {N_VEC{1'b0}};
                        r_mm    <= {(N_IN+1){1'b0}};
                        r_match <= 1'b0;
                        r_idx   <= {N_IN{1'b0}};
                        r_busy  <= 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_expire) begin
                        r_table[r_idx] <= i_lut_f;
                        r_mm           <= w_mm_next;
                        // The index is cleared rather than wrapped so lut_in reads 0 in DONE.
                        if (w_last) begin
                            r_idx   <= {N_IN{1'b0}};
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_match <= (w_mm_next == {(N_IN+1){1'b0}});
                        end else begin
                            r_idx <= r_idx + N_IN'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= {N_IN{1'b0}};
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_lut_in         = r_idx;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_table          = r_table;
    assign o_match          = r_match;
    assign o_mismatch_count = r_mm;

endmodule

// File: tb/tb_lut_sweep_capture.sv
// Self-checking bench: random truth tables driven through a combinational LUT model,
// with results predicted from the table/expected pair directly.
module tb_lut_sweep_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] exp0, exp1, tbl0, tbl1;
    logic [2:0] lut_in0, lut_in1;
    logic       f0, f1;
    logic       busy0, busy1, done0, done1, match0, match1;
    logic [7:0] table0, table1;
    logic [3:0] mm0, mm1;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign f0 = tbl0[lut_in0];
    assign f1 = tbl1[lut_in1];

    lut_sweep_capture #(.N_IN(3), .SETTLE(2)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_expected(exp0),
        .o_lut_in(lut_in0), .i_lut_f(f0), .o_busy(busy0), .o_done(done0),
        .o_table(table0), .o_match(match0), .o_mismatch_count(mm0)
    );

    lut_sweep_capture #(.N_IN(3), .SETTLE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_expected(exp1),
        .o_lut_in(lut_in1), .i_lut_f(f1), .o_busy(busy1), .o_done(done1),
        .o_table(table1), .o_match(match1), .o_mismatch_count(mm1)
    );

    function automatic int popcount(input logic [7:0] x);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(x[i]);
        return n;
    endfunction

    // F = A&B | C with A = bit2, B = bit1, C = bit0 of the vector.
    function automatic logic [7:0] table_and_or();
        logic [7:0] t;
        for (int v = 0; v < 8; v++) t[v] = ((v / 4) % 2 == 1 && (v / 2) % 2 == 1) || (v % 2 == 1);
        return t;
    endfunction

    function automatic logic [7:0] table_not_a();
        logic [7:0] t;
        for (int v = 0; v < 8; v++) t[v] = (v < 4);
        return t;
    endfunction

    // Entered just before the accepting edge; returns at the negedge of the DONE cycle.
    task automatic run_sweep(input logic [7:0] tbl, input logic [7:0] exp, input int hold,
                             input bit scramble, input string name);
        int want_mm;
        want_mm = popcount(tbl ^ exp);
        tbl0 = tbl; exp0 = exp; start0 = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (hold != 0 && c + 1 >= hold) start0 = 1'b0;
            if (scramble) exp0 = 8'($urandom);
            checks++;
            if (lut_in0 !== 3'(c / 2)) begin
                errs++; $display("FAIL %s lut_in c=%0d: got %0d want %0d", name, c, lut_in0, c / 2);
            end
            checks++;
            if (busy0 !== 1'b1 || done0 !== 1'b0) begin
                errs++; $display("FAIL %s busy/done c=%0d: got %b/%b want 1/0", name, c, busy0, done0);
            end
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || lut_in0 !== 3'd0) begin
            errs++; $display("FAIL %s done-cycle: done=%b busy=%b lut_in=%0d want 1,0,0", name, done0, busy0, lut_in0);
        end
        checks++;
        if (table0 !== tbl) begin
            errs++; $display("FAIL %s table: got %h want %h", name, table0, tbl);
        end
        checks++;
        if (match0 !== (tbl == exp) || int'(mm0) != want_mm) begin
            errs++; $display("FAIL %s match/mm: got %b/%0d want %b/%0d", name, match0, mm0, tbl == exp, want_mm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
        exp0 = 8'hFF; exp1 = 8'hFF; tbl0 = 8'hFF; tbl1 = 8'hFF;
        repeat (2) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || lut_in0 !== 3'd0 || table0 !== 8'h00 ||
            mm0 !== 4'd0 || match0 !== 1'b0) begin
            errs++; $display("FAIL reset dut0: busy=%b done=%b lut_in=%0d table=%h mm=%0d match=%b want all 0",
                             busy0, done0, lut_in0, table0, mm0, match0);
        end
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || lut_in1 !== 3'd0 || table1 !== 8'h00 || mm1 !== 4'd0) begin
            errs++; $display("FAIL reset dut1: busy=%b done=%b lut_in=%0d table=%h mm=%0d want all 0",
                             busy1, done1, lut_in1, table1, mm1);
        end
        start0 = 1'b0; start1 = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_golden();
        run_sweep(table_and_or(), 8'hEA, 1, 1'b0, "golden");
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done0 !== 1'b0 || busy0 !== 1'b0 || table0 !== 8'hEA || match0 !== 1'b1 || mm0 !== 4'd0) begin
                errs++; $display("FAIL golden hold: done=%b busy=%b table=%h match=%b mm=%0d want 0,0,EA,1,0",
                                 done0, busy0, table0, match0, mm0);
            end
        end
    endtask

    task automatic test_mismatch();
        run_sweep(table_and_or(), 8'h00, 1, 1'b0, "mismatch");
        checks++;
        if (mm0 !== 4'd5) begin
            errs++; $display("FAIL mismatch count: got %0d want 5", mm0);
        end
        @(negedge clk);
    endtask

    task automatic test_expected_change();
        run_sweep(table_and_or(), 8'hEA, 1, 1'b1, "exp_change");
        @(negedge clk);
    endtask

    task automatic test_start_hold3();
        int dones = 0;
        run_sweep(table_and_or(), 8'hEA, 3, 1'b0, "hold3");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errs++; $display("FAIL hold3 extra activity: got %0d busy/done cycles want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] t2, e2;
        t2 = 8'($urandom); e2 = 8'($urandom);
        run_sweep(table_and_or(), 8'hEA, 0, 1'b0, "b2b_first");
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || lut_in0 !== 3'd0) begin
            errs++; $display("FAIL b2b idle gap: busy=%b done=%b lut_in=%0d want 0,0,0", busy0, done0, lut_in0);
        end
        run_sweep(t2, e2, 1, 1'b0, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int dones = 0;
        tbl0 = table_and_or(); exp0 = 8'hEA; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (lut_in0 !== 3'd3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errs++; $display("FAIL reset_mid reach idx3: got lut_in=%0d want 3 within 20 cycles", lut_in0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || lut_in0 !== 3'd0 || table0 !== 8'h00 ||
            mm0 !== 4'd0 || match0 !== 1'b0) begin
            errs++; $display("FAIL reset_mid values: busy=%b done=%b lut_in=%0d table=%h mm=%0d match=%b want all 0",
                             busy0, done0, lut_in0, table0, mm0, match0);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errs++; $display("FAIL reset_mid no-done: got %0d busy/done cycles want 0", dones);
        end
        run_sweep(table_and_or(), 8'hEA, 1, 1'b0, "after_reset");
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] t, e;
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom);
            e = ($urandom_range(0, 2) == 0) ? t : 8'($urandom);
            run_sweep(t, e, $urandom_range(1, 6), 1'($urandom_range(0, 1)), "random");
            @(negedge clk);
        end
    endtask

    task automatic test_settle1();
        tbl1 = table_not_a(); exp1 = 8'h0F; start1 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            checks++;
            if (lut_in1 !== 3'(c) || busy1 !== 1'b1 || done1 !== 1'b0) begin
                errs++; $display("FAIL settle1 c=%0d: lut_in=%0d busy=%b done=%b want %0d,1,0",
                                 c, lut_in1, busy1, done1, c);
            end
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1 || table1 !== 8'h0F || match1 !== 1'b1 || mm1 !== 4'd0) begin
            errs++; $display("FAIL settle1 result: done=%b table=%h match=%b mm=%0d want 1,0F,1,0",
                             done1, table1, match1, mm1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            errs++; $display("FAIL settle1 done width: got %b want 0", done1);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mismatch();
        test_expected_change();
        test_start_hold3();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_settle1();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
